// File: rtl/counter_pkg.sv
// Shared constants for the modulo counter: direction encodings and default geometry.
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned DEF_WIDTH    = 2;
  localparam int unsigned DEF_MODULUS  = 4;
  localparam int unsigned DEF_PRESCALE = 1;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; clr restarts the phase.
module tick_gen #(
  parameter int unsigned PRESCALE = counter_pkg::DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "tick_gen: PRESCALE must be >= 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // With PRESCALE=1 cnt stays at 0, so tick simply follows en.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/param_counter.sv
// Modulo-N counter with prescaler, clamped synchronous load, wrap pulse and
// active-low one-hot select. Define COUNTER_DOWN_EN to add the dir input.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MODULUS  = DEF_MODULUS,
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
`ifdef COUNTER_DOWN_EN
  input  logic               dir,
`endif
  output logic [WIDTH-1:0]   Q,
  output logic               tc,
  output logic [MODULUS-1:0] sel_n
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "param_counter: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "param_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "param_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  dir_e             cur_dir;
  logic             step;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

`ifdef COUNTER_DOWN_EN
  assign cur_dir = dir_e'(dir);
`else
  assign cur_dir = DIR_UP;
`endif

  // Load clears the prescaler phase so counting restarts cleanly from load_val.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (step)
  );

  // Next count: load (clamped) beats step; tc marks a wrap in either direction.
  always_comb begin
    q_nxt  = Q;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = (load_val > Q_MAX) ? Q_MAX : load_val;
    end else if (step) begin
      if (cur_dir == DIR_DOWN) begin
        if (Q == '0) begin
          q_nxt  = Q_MAX;
          tc_nxt = 1'b1;
        end else begin
          q_nxt = Q - WIDTH'(1);
        end
      end else if (Q == Q_MAX) begin
        q_nxt  = '0;
        tc_nxt = 1'b1;
      end else begin
        q_nxt = Q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q  <= '0;
      tc <= 1'b0;
    end else begin
      Q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

  assign sel_n = ~(MODULUS'(1) << Q);

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three configurations driven together and compared
// every cycle against a modular-arithmetic reference model.
module tb_param_counter;

  localparam int WIDS [3] = '{2, 2, 3};
  localparam int MODS [3] = '{4, 3, 6};
  localparam int PRES [3] = '{1, 4, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic       en_v   [3];
  logic       load_v [3];
  logic [2:0] lv     [3];
`ifdef COUNTER_DOWN_EN
  logic       dir_v  [3];
`endif

  logic [1:0] q0, q1;
  logic [2:0] q2;
  logic       tc0, tc1, tc2;
  logic [3:0] sel0;
  logic [2:0] sel1;
  logic [5:0] sel2;

  int mq [3];
  int mpre [3];
  int mtc [3];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(2), .MODULUS(4), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en_v[0]), .load(load_v[0]), .load_val(lv[0][1:0]),
`ifdef COUNTER_DOWN_EN
    .dir(dir_v[0]),
`endif
    .Q(q0), .tc(tc0), .sel_n(sel0));

  param_counter #(.WIDTH(2), .MODULUS(3), .PRESCALE(4)) u_b (
    .clk(clk), .rst(rst), .en(en_v[1]), .load(load_v[1]), .load_val(lv[1][1:0]),
`ifdef COUNTER_DOWN_EN
    .dir(dir_v[1]),
`endif
    .Q(q1), .tc(tc1), .sel_n(sel1));

  param_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(3)) u_c (
    .clk(clk), .rst(rst), .en(en_v[2]), .load(load_v[2]), .load_val(lv[2]),
`ifdef COUNTER_DOWN_EN
    .dir(dir_v[2]),
`endif
    .Q(q2), .tc(tc2), .sel_n(sel2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_q(input int i);
    case (i)
      0:       return 32'(q0);
      1:       return 32'(q1);
      default: return 32'(q2);
    endcase
  endfunction

  function automatic logic [31:0] obs_tc(input int i);
    case (i)
      0:       return 32'(tc0);
      1:       return 32'(tc1);
      default: return 32'(tc2);
    endcase
  endfunction

  function automatic logic [31:0] obs_sel(input int i);
    case (i)
      0:       return 32'(sel0);
      1:       return 32'(sel1);
      default: return 32'(sel2);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mpre[i] = 0; mtc[i] = 0;
    end
  endtask

  // One clock edge of the reference: phase advances modulo PRESCALE, count modulo MODULUS.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int down;
      int v;
      down = 0;
`ifdef COUNTER_DOWN_EN
      down = int'(dir_v[i]);
`endif
      mtc[i] = 0;
      if (rst) begin
        mq[i] = 0; mpre[i] = 0;
      end else if (load_v[i]) begin
        v = int'(lv[i]) & ((1 << WIDS[i]) - 1);
        mq[i] = (v >= MODS[i]) ? MODS[i] - 1 : v;
        mpre[i] = 0;
      end else if (en_v[i]) begin
        mpre[i] = (mpre[i] + 1) % PRES[i];
        if (mpre[i] == 0) begin
          mq[i] = down ? (mq[i] + MODS[i] - 1) % MODS[i] : (mq[i] + 1) % MODS[i];
          mtc[i] = (mq[i] == (down ? MODS[i] - 1 : 0)) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q%0d", i), obs_q(i), 32'(mq[i]));
      chk($sformatf("tc%0d", i), obs_tc(i), 32'(mtc[i]));
      chk($sformatf("sel%0d", i), obs_sel(i),
          32'((~(1 << mq[i])) & ((1 << MODS[i]) - 1)));
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_all(input logic en, input logic ld);
    for (int i = 0; i < 3; i++) begin
      en_v[i] = en; load_v[i] = ld;
    end
  endtask

  initial begin
    int exp_a [4] = '{1, 2, 3, 0};
    rst = 1'b1;
    set_all(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) lv[i] = '0;
`ifdef COUNTER_DOWN_EN
    for (int i = 0; i < 3; i++) dir_v[i] = 1'b0;
`endif
    model_reset();
    #1;
    chk("rst_q0", 32'(q0), 32'd0);
    chk("rst_sel0", 32'(sel0), 32'd14);
    step_clk();
    step_clk();
    rst = 1'b0;

    // Free run: A wraps every 4 cycles, B steps every 4, C every 3.
    set_all(1'b1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step_clk();
      chk("run_a_q", 32'(q0), 32'(exp_a[k % 4]));
      chk("run_a_tc", 32'(tc0), (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    chk("run_b_q", 32'(q1), 32'd0);
    chk("run_b_tc", 32'(tc1), 32'd1);
    chk("run_c_q", 32'(q2), 32'd4);

    // Clamped load, then a mid-prescale load that restarts the phase.
    load_v[2] = 1'b1; lv[2] = 3'd7;
    step_clk();
    chk("load_clamp", 32'(q2), 32'd5);
    load_v[2] = 1'b0;
    step_clk();
    load_v[2] = 1'b1; lv[2] = 3'd2;
    step_clk();
    chk("load_mid", 32'(q2), 32'd2);
    load_v[2] = 1'b0;
    step_clk();
    step_clk();
    chk("load_phase_hold", 32'(q2), 32'd2);
    step_clk();
    chk("load_phase_step", 32'(q2), 32'd3);

    // Ten-cycle enable gap mid-prescale.
    step_clk();
    set_all(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step_clk();
    chk("gap_hold", 32'(q2), 32'd3);
    set_all(1'b1, 1'b0);
    step_clk();
    chk("gap_resume1", 32'(q2), 32'd3);
    step_clk();
    chk("gap_resume2", 32'(q2), 32'd4);

    // Asynchronous reset pulse between edges with A at 3.
    set_all(1'b0, 1'b0);
    load_v[0] = 1'b1; lv[0] = 3'd3;
    step_clk();
    chk("pre_arst_q0", 32'(q0), 32'd3);
    load_v[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_q0", 32'(q0), 32'd0);
    chk("arst_sel0", 32'(sel0), 32'd14);
    chk("arst_tc0", 32'(tc0), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    step_clk();

`ifdef COUNTER_DOWN_EN
    // Down mode on A: 0,3,2,1,0 with tc after the 0->3 wrap.
    for (int i = 0; i < 3; i++) dir_v[i] = 1'b1;
    set_all(1'b1, 1'b0);
    begin
      int exp_d [4] = '{3, 2, 1, 0};
      for (int k = 0; k < 4; k++) begin
        step_clk();
        chk("down_q", 32'(q0), 32'(exp_d[k]));
        chk("down_tc", 32'(tc0), (k == 0) ? 32'd1 : 32'd0);
      end
    end
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        en_v[i]   = ($urandom % 8) != 0;
        load_v[i] = ($urandom % 16) == 0;
        lv[i]     = 3'($urandom);
`ifdef COUNTER_DOWN_EN
        if ($urandom % 32 == 0) dir_v[i] = ~dir_v[i];
`endif
      end
      rst = ($urandom % 200) == 0;
      step_clk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning count register width in bits; legal range 1..16.
REQ-002 SHALL have parameter MODULUS, default 4, meaning number of count states (0..MODULUS-1); legal range 2..2^WIDTH.
REQ-003 SHALL have parameter PRESCALE, default 1, meaning enabled clock cycles per count step; legal range >=1.
REQ-004 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-009 SHALL have port Q, output, WIDTH bits: registered count value.
REQ-010 SHALL have port tc, output, 1 bit: registered terminal-count (wrap) pulse.
REQ-011 SHALL have port sel_n, output, MODULUS bits: active-low one-hot decode of Q (digit/mole select).

Function
REQ-012 SHALL contain a prescaler counting 0..PRESCALE-1 on each clk edge with en=1; step is asserted when prescaler==PRESCALE-1 and en=1, after which the prescaler returns to 0.
REQ-013 SHALL assert step on every cycle with en=1 when PRESCALE=1.
REQ-014 SHALL hold Q, the prescaler and tc=0 on any cycle with en=0 and load=0.
REQ-015 SHALL, on step in up mode, set Q to Q+1, or to 0 when Q==MODULUS-1.
REQ-016 SHALL drive tc high for exactly the one cycle following the edge at which Q wraps, and low otherwise.
REQ-017 SHALL give load priority over en and step: on load=1, Q takes load_val, the prescaler resets to 0 and tc is 0.
REQ-018 SHALL clamp a load_val >= MODULUS to MODULUS-1.
REQ-019 SHALL drive sel_n combinationally from Q: bit Q low and all other bits high.
REQ-020 SHALL never present a Q value >= MODULUS.
REQ-021 SHALL have a latency of one clk edge from step or load to Q update.

Reset
REQ-022 SHALL, while rst=1, immediately force Q=0, tc=0, prescaler=0 and sel_n={all ones except bit 0 low}, independent of clk.
REQ-023 SHALL resume counting on the first clk edge after rst deasserts with en=1, starting from prescaler 0.
REQ-024 SHALL treat rst asserted mid-prescale or mid-load as a full reset, with no partial step retained.

Configuration
REQ-025 SHALL, when macro COUNTER_DOWN_EN is defined, add input port dir (1 bit, 0=up, 1=down).
REQ-026 SHALL, with dir=1 on step, set Q to Q-1, or to MODULUS-1 when Q==0, and pulse tc as in REQ-016.
REQ-027 SHALL, when COUNTER_DOWN_EN is undefined, omit dir and count up only.
REQ-028 SHALL, under COUNTER_DOWN_EN, apply a dir change on the next step without resetting the prescaler.

Structure
REQ-029 SHALL place the direction encodings (DIR_UP=0, DIR_DOWN=1) and the default WIDTH, MODULUS and PRESCALE constants in shared package counter_pkg.
REQ-030 SHALL implement the prescaler as sub-module tick_gen (parameter PRESCALE; ports clk, rst, en, clr, tick).
REQ-031 SHALL check parameter legality at elaboration and fail on illegal values.

Verification
REQ-032 SHALL cover free run with WIDTH=2, MODULUS=4, PRESCALE=1, en=1: Q sequence 0,1,2,3,0 and tc high only in the cycle after 3->0.
REQ-033 SHALL cover MODULUS=3, PRESCALE=4: Q advances every 4 cycles in the sequence 0,1,2,0, and sel_n follows 110,101,011,110.
REQ-034 SHALL cover load with en=1, WIDTH=3, MODULUS=6: load=1 with load_val=7 -> Q=5; load=1 with load_val=2 mid-prescale -> Q=2 and prescaler restarts.
REQ-035 SHALL cover an en=0 gap of 10 cycles mid-prescale: Q, prescaler and tc are frozen, and counting resumes exactly where it stopped.
REQ-036 SHALL cover an asynchronous rst pulse between clk edges with Q=3: Q=0 and sel_n=1110 before the next edge, and tc=0.
REQ-037 SHALL cover down mode under COUNTER_DOWN_EN with dir=1 and MODULUS=4: Q sequence 0,3,2,1,0 and tc pulses after the 0->3 step.
